// File: rtl/bus_rx_fifo8.sv
// bus_rx_fifo8 - receive side of the shared 8-bit tristate data bus.
//
// Samples the bus on a capture strobe (ld). The byte is queued only when
// exactly one bus driver has its T line low. Queued bytes are drained through
// a valid/ready handshake. Sticky error flags record three kinds of event:
// a floating bus, driver contention, and a capture dropped because the FIFO
// was full.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   bus[7:0]      shared data bus
//   drv_t[NDRV]   driver output-disable lines (0 = driving)
//   ld            capture strobe
//   out_data[7:0] head byte (8'h00 when empty)
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts head byte
//   count         occupancy, 0..DEPTH
//   full, empty   occupancy status
//   err_float     sticky: capture with no driver enabled
//   err_conflict  sticky: capture with more than one driver enabled
//   err_ovf       sticky: valid capture dropped while full
//   err_clr       synchronous clear of the sticky flags
module bus_rx_fifo8 #(
  parameter int DEPTH = 4,
  parameter int NDRV  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               bus,
  input  logic [NDRV-1:0]          drv_t,
  input  logic                     ld,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err_float,
  output logic                     err_conflict,
  output logic                     err_ovf,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int ZW = $clog2(NDRV + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          err_float_reg, err_float_next;
  logic          err_conflict_reg, err_conflict_next;
  logic          err_ovf_reg, err_ovf_next;

  logic [ZW-1:0] n_enabled;
  logic          one_drv;
  logic          no_drv;
  logic          multi_drv;
  logic          push;
  logic          pop;
  logic          ovf_evt;

  // Count drivers that are actively driving (T line low).
  always_comb begin
    n_enabled = '0;
    for (int i = 0; i < NDRV; i++) begin
      n_enabled = n_enabled + ZW'(~drv_t[i]);
    end
  end

  assign one_drv   = (n_enabled == ZW'(1));
  assign no_drv    = (n_enabled == '0);
  assign multi_drv = !no_drv && !one_drv;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign out_valid = !empty;
  assign count     = count_reg;

  // out_ready is only honoured while a byte is presented.
  assign pop = out_valid && out_ready;

  // A simultaneous pop frees the slot, so a push into a full FIFO is legal
  // on that edge.
  assign push    = ld && one_drv && (!full || pop);
  assign ovf_evt = ld && one_drv && full && !pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
    // A new event wins over a clear on the same edge.
    err_float_next    = (err_float_reg    && !err_clr) || (ld && no_drv);
    err_conflict_next = (err_conflict_reg && !err_clr) || (ld && multi_drv);
    err_ovf_next      = (err_ovf_reg      && !err_clr) || ovf_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      err_float_reg    <= 1'b0;
      err_conflict_reg <= 1'b0;
      err_ovf_reg      <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      err_float_reg    <= err_float_next;
      err_conflict_reg <= err_conflict_next;
      err_ovf_reg      <= err_ovf_next;
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus;
    end
  end

  assign out_data     = empty ? 8'h00 : mem[rd_ptr_reg];
  assign err_float    = err_float_reg;
  assign err_conflict = err_conflict_reg;
  assign err_ovf      = err_ovf_reg;

endmodule
